periph_plug_rr_arbiter: RTL and testbench
=========================================

# periph_plug_rr_arbiter

Round-robin arbiter that shares one cluster peripheral target port between NB_PLUGS peripheral-interconnect plugs (XBAR_PERIPH_BUS request/grant, decoupled r_valid response). It replaces priority-mux plug combining in front of the event unit and other multi-plug peripherals. It keeps an in-order table of outstanding grants so each response returns only to the plug that issued it. Sits between the peripheral interconnect slave plugs and the target peripheral inside cluster_peripherals.

## Interface
- NB_PLUGS, 2: number of requesting plugs (≥2).
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width; BE width is DATA_WIDTH/8.
- ID_WIDTH, 5: transaction id width (NB_CORES+1).
- MAX_OUTSTANDING, 2: granted transactions awaiting r_valid (≥1).

Ports:
- clk_i  in  1  cluster clock.
- rst_ni  in  1  asynchronous active-low reset.
- plug_req_i  in  NB_PLUGS  per-plug request.
- plug_add_i  in  NB_PLUGS×ADDR_WIDTH  address.
- plug_wen_i  in  NB_PLUGS  0 = write, 1 = read.
- plug_wdata_i  in  NB_PLUGS×DATA_WIDTH  write data.
- plug_be_i  in  NB_PLUGS×DATA_WIDTH/8  byte enables.
- plug_id_i  in  NB_PLUGS×ID_WIDTH  transaction id.
- plug_gnt_o  out  NB_PLUGS  grant, one-hot or zero.
- plug_r_valid_o  out  NB_PLUGS  response valid, one-hot or zero.
- plug_r_rdata_o  out  DATA_WIDTH  response data, broadcast.
- plug_r_opc_o  out  1  response error, broadcast.
- plug_r_id_o  out  ID_WIDTH  response id, broadcast.
- per_req_o, per_add_o, per_wen_o, per_wdata_o, per_be_o, per_id_o  out  as above  target request.
- per_gnt_i  in  1  target grant.
- per_r_valid_i, per_r_rdata_i, per_r_opc_i, per_r_id_i  in  as above  target response.
- busy_o  out  1  at least one transaction outstanding.
- err_o  out  1  one-cycle pulse: r_valid with no outstanding entry.

## Operation
- Arbitration state: priority pointer prio_q (log2 NB_PLUGS bits, reset 0); lock state lock_q/lock_idx_q (reset 0).
- Selection when unlocked: first requesting plug at or after prio_q, wrapping modulo NB_PLUGS.
- Lock: if per_req_o is high and per_gnt_i is low, set lock_q and hold lock_idx_q = selected plug. While locked, the selected plug is lock_idx_q regardless of other requests, so the target never sees the request change before it grants. Lock clears on handshake.
- If the locked plug drops req before grant (protocol violation), clear the lock and re-arbitrate in the same cycle.
- Handshake is per_req_o & per_gnt_i. On handshake: plug_gnt_o[sel] = 1; prio_q ← sel+1 mod NB_PLUGS; push sel into outstanding FIFO.
- Outstanding FIFO: depth MAX_OUTSTANDING, entries are plug indices, with rd/wr pointers and count (reset 0).
- Full FIFO: per_req_o forced 0 and all plug_gnt_o 0. Full blocks new grants even when a pop occurs in the same cycle. Lock state is preserved.
- On per_r_valid_i with count>0: plug_r_valid_o[head] = 1 and the FIFO pops. rdata/opc/id pass through unregistered.
- On per_r_valid_i with count==0: no plug_r_valid_o, err_o = 1 for that cycle, FIFO unchanged.
- Simultaneous push and pop (not full): count unchanged; both pointers advance; wrap modulo MAX_OUTSTANDING.
- busy_o = (count != 0).
- Reset mid-transaction: FIFO, lock and pointer clear. Responses arriving later flag err_o and are dropped.

## Timing
- Request path is combinational, zero cycles: plug inputs → per_* outputs, and per_gnt_i → plug_gnt_o.
- Response path is combinational, zero cycles: per_r_* → plug_r_*.
- The earliest response to a grant in cycle N is cycle N+1, from the same-cycle FIFO push.
- Back-to-back grants to alternating plugs every cycle are supported while the FIFO is not full. Throughput is one transaction per cycle with MAX_OUTSTANDING ≥ 2 and a 1-cycle target.
- Reset values: per_req_o 0, plug_gnt_o 0, plug_r_valid_o 0, busy_o 0, err_o 0. per_add/wdata/be/id/wen are don't-care when per_req_o is 0; drive plug 0's values.
- State updates on the rising clk_i edge only; reset acts asynchronously on assertion.

## Test plan
- Both plugs request continuously; target gnt=1, r_valid 1 cycle later → grants alternate 0,1,0,1. Each r_valid is routed to the matching plug with per_r_id_i echoed.
- Plug 1 alone, then plug 0 joins while the target stalls gnt for 3 cycles → per_add_o stays at plug 1's address until gnt. Plug 0 is granted next.
- MAX_OUTSTANDING=2, target grants but withholds r_valid → exactly 2 grants, then per_req_o=0 and busy_o=1. On one r_valid, the next cycle grants again.
- Full FIFO with r_valid and a pending request in the same cycle → no grant that cycle, count drops to 1, grant issues the following cycle.
- Spurious per_r_valid_i with nothing outstanding → err_o pulses 1 cycle, plug_r_valid_o stays 0.
- Assert rst_ni low with 2 outstanding → all outputs at reset values. A later r_valid raises err_o only.

Source files
------------

// File: rtl/periph_plug_rr_arbiter.sv
// Round-robin arbiter sharing one peripheral target port between NB_PLUGS plugs,
// with an in-order table of outstanding grants that routes each r_valid back.
module periph_plug_rr_arbiter #(
    parameter int NB_PLUGS        = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 5,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NB_PLUGS-1:0]               plug_req_i,
    input  logic [NB_PLUGS*ADDR_WIDTH-1:0]    plug_add_i,
    input  logic [NB_PLUGS-1:0]               plug_wen_i,
    input  logic [NB_PLUGS*DATA_WIDTH-1:0]    plug_wdata_i,
    input  logic [NB_PLUGS*DATA_WIDTH/8-1:0]  plug_be_i,
    input  logic [NB_PLUGS*ID_WIDTH-1:0]      plug_id_i,
    output logic [NB_PLUGS-1:0]               plug_gnt_o,
    output logic [NB_PLUGS-1:0]               plug_r_valid_o,
    output logic [DATA_WIDTH-1:0]             plug_r_rdata_o,
    output logic                              plug_r_opc_o,
    output logic [ID_WIDTH-1:0]               plug_r_id_o,
    output logic                              per_req_o,
    output logic [ADDR_WIDTH-1:0]             per_add_o,
    output logic                              per_wen_o,
    output logic [DATA_WIDTH-1:0]             per_wdata_o,
    output logic [DATA_WIDTH/8-1:0]           per_be_o,
    output logic [ID_WIDTH-1:0]               per_id_o,
    input  logic                              per_gnt_i,
    input  logic                              per_r_valid_i,
    input  logic [DATA_WIDTH-1:0]             per_r_rdata_i,
    input  logic                              per_r_opc_i,
    input  logic [ID_WIDTH-1:0]               per_r_id_i,
    output logic                              busy_o,
    output logic                              err_o
);

    localparam int PW = (NB_PLUGS > 1) ? $clog2(NB_PLUGS) : 1;
    localparam int OW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = DATA_WIDTH / 8;
    localparam logic [PW-1:0] LAST_PLUG = PW'(NB_PLUGS - 1);
    localparam logic [OW-1:0] LAST_SLOT = OW'(MAX_OUTSTANDING - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(MAX_OUTSTANDING);

    logic [PW-1:0] prio_q;
    logic          lock_q;
    logic [PW-1:0] lock_idx_q;
    logic [PW-1:0] fifo_q [MAX_OUTSTANDING];
    logic [OW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic [PW-1:0] sel, cand, mux_idx;
    logic          any_req, full, hs, pop;

    // A held lock pins the selection so the target sees a stable request until it grants.
    always_comb begin
        sel     = '0;
        cand    = '0;
        any_req = 1'b0;
        if (lock_q && plug_req_i[lock_idx_q]) begin
            sel     = lock_idx_q;
            any_req = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NB_PLUGS; i++) begin
                cand = PW'((32'(prio_q) + i) % NB_PLUGS);
                if (!any_req && plug_req_i[cand]) begin
                    any_req = 1'b1;
                    sel     = cand;
                end
            end
        end
    end

    assign full      = (count_q == FULL_CNT);
    assign per_req_o = any_req && !full;
    assign hs        = per_req_o && per_gnt_i;
    assign pop       = per_r_valid_i && (count_q != '0);
    assign mux_idx   = per_req_o ? sel : '0;

    assign per_add_o   = plug_add_i[mux_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign per_wen_o   = plug_wen_i[mux_idx];
    assign per_wdata_o = plug_wdata_i[mux_idx*DATA_WIDTH +: DATA_WIDTH];
    assign per_be_o    = plug_be_i[mux_idx*BW +: BW];
    assign per_id_o    = plug_id_i[mux_idx*ID_WIDTH +: ID_WIDTH];

    always_comb begin
        plug_gnt_o     = '0;
        plug_r_valid_o = '0;
        if (hs)  plug_gnt_o[sel] = 1'b1;
        if (pop) plug_r_valid_o[fifo_q[rd_ptr_q]] = 1'b1;
    end

    assign plug_r_rdata_o = per_r_rdata_i;
    assign plug_r_opc_o   = per_r_opc_i;
    assign plug_r_id_o    = per_r_id_i;
    assign busy_o         = (count_q != '0);
    assign err_o          = per_r_valid_i && (count_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q     <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
        end else begin
            if (hs) begin
                prio_q           <= (sel == LAST_PLUG) ? '0 : sel + 1'b1;
                fifo_q[wr_ptr_q] <= sel;
                wr_ptr_q         <= (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + 1'b1;
            if (hs && !pop)      count_q <= count_q + 1'b1;
            else if (!hs && pop) count_q <= count_q - 1'b1;
            // Full FIFO keeps per_req_o low, so the lock is neither set nor released by it.
            if (hs)                                     lock_q <= 1'b0;
            else if (per_req_o) begin
                lock_q     <= 1'b1;
                lock_idx_q <= sel;
            end else if (lock_q && !plug_req_i[lock_idx_q]) lock_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_periph_plug_rr_arbiter.sv
// Table-driven bench for periph_plug_rr_arbiter; a response scoreboard tracks which
// plug owns each outstanding grant.
module tb_periph_plug_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  plug_req = '0;
    logic [63:0] plug_add = {32'h2000_0200, 32'h1000_0100};
    logic [1:0]  plug_wen = 2'b01;
    logic [63:0] plug_wdata = {32'hBBBB_0002, 32'hAAAA_0001};
    logic [7:0]  plug_be = 8'hF3;
    logic [9:0]  plug_id = {5'd4, 5'd3};
    logic [1:0]  plug_gnt, plug_r_valid;
    logic [31:0] plug_r_rdata;
    logic        plug_r_opc;
    logic [4:0]  plug_r_id;
    logic        per_req, per_wen;
    logic [31:0] per_add, per_wdata;
    logic [3:0]  per_be;
    logic [4:0]  per_id;
    logic        per_gnt = 1'b0, per_r_valid = 1'b0, per_r_opc = 1'b0;
    logic [31:0] per_r_rdata = '0;
    logic [4:0]  per_r_id = '0;
    logic        busy, err;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    periph_plug_rr_arbiter #(
        .NB_PLUGS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(5), .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .plug_req_i(plug_req), .plug_add_i(plug_add), .plug_wen_i(plug_wen),
        .plug_wdata_i(plug_wdata), .plug_be_i(plug_be), .plug_id_i(plug_id),
        .plug_gnt_o(plug_gnt), .plug_r_valid_o(plug_r_valid), .plug_r_rdata_o(plug_r_rdata),
        .plug_r_opc_o(plug_r_opc), .plug_r_id_o(plug_r_id),
        .per_req_o(per_req), .per_add_o(per_add), .per_wen_o(per_wen),
        .per_wdata_o(per_wdata), .per_be_o(per_be), .per_id_o(per_id),
        .per_gnt_i(per_gnt), .per_r_valid_i(per_r_valid), .per_r_rdata_i(per_r_rdata),
        .per_r_opc_i(per_r_opc), .per_r_id_i(per_r_id),
        .busy_o(busy), .err_o(err)
    );

    typedef struct {
        logic [1:0] req;
        logic       gnt;
        logic       rv;
        logic [1:0] e_gnt;
        logic       e_preq;
        logic       e_sel;
        logic       e_busy;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] req, input logic gnt, input logic rv,
                                input logic [1:0] e_gnt, input logic e_preq,
                                input logic e_sel, input logic e_busy);
        vec_t v;
        v.req = req; v.gnt = gnt; v.rv = rv; v.e_gnt = e_gnt;
        v.e_preq = e_preq; v.e_sel = e_sel; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_row(input vec_t v);
        int          p;
        logic [1:0]  exp_rv;
        logic        exp_err;
        logic [31:0] exp_add;
        @(posedge clk); #1;
        plug_req    = v.req;
        per_gnt     = v.gnt;
        per_r_valid = v.rv;
        per_r_rdata = $urandom;
        per_r_opc   = 1'($urandom_range(0, 1));
        per_r_id    = '0;
        exp_rv      = '0;
        exp_err     = 1'b0;
        if (v.rv) begin
            if (exp_q.size() > 0) begin
                p        = exp_q.pop_front();
                exp_rv   = (p == 0) ? 2'b01 : 2'b10;
                per_r_id = 5'(p + 3);
            end else begin
                exp_err = 1'b1;
            end
        end
        if (v.e_gnt[0]) exp_q.push_back(0);
        if (v.e_gnt[1]) exp_q.push_back(1);
        exp_add = v.e_sel ? 32'h2000_0200 : 32'h1000_0100;
        @(negedge clk);
        check("plug_gnt", 32'(plug_gnt), 32'(v.e_gnt));
        check("per_req", 32'(per_req), 32'(v.e_preq));
        check("per_add", per_add, exp_add);
        check("per_id", 32'(per_id), v.e_sel ? 32'd4 : 32'd3);
        check("per_wen", 32'(per_wen), v.e_sel ? 32'd0 : 32'd1);
        check("busy", 32'(busy), 32'(v.e_busy));
        check("plug_r_valid", 32'(plug_r_valid), 32'(exp_rv));
        check("err", 32'(err), 32'(exp_err));
        if (v.rv && !exp_err) begin
            check("r_id", 32'(plug_r_id), 32'(per_r_id));
            check("r_rdata", plug_r_rdata, per_r_rdata);
            check("r_opc", 32'(plug_r_opc), 32'(per_r_opc));
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_per_req", 32'(per_req), 32'd0);
        check("rst_plug_gnt", 32'(plug_gnt), 32'd0);
        check("rst_plug_r_valid", 32'(plug_r_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
    endtask

    vec_t tbl[23];

    initial begin
        // alternating grants with 1-cycle responses
        tbl[0]  = mk(2'b11, 1, 0, 2'b01, 1, 0, 0);
        tbl[1]  = mk(2'b11, 1, 1, 2'b10, 1, 1, 1);
        tbl[2]  = mk(2'b11, 1, 1, 2'b01, 1, 0, 1);
        tbl[3]  = mk(2'b11, 1, 1, 2'b10, 1, 1, 1);
        tbl[4]  = mk(2'b00, 0, 1, 2'b00, 0, 0, 1);
        // plug 1 locked through a 3-cycle stall, plug 0 next
        tbl[5]  = mk(2'b10, 0, 0, 2'b00, 1, 1, 0);
        tbl[6]  = mk(2'b11, 0, 0, 2'b00, 1, 1, 0);
        tbl[7]  = mk(2'b11, 0, 0, 2'b00, 1, 1, 0);
        tbl[8]  = mk(2'b11, 1, 0, 2'b10, 1, 1, 0);
        tbl[9]  = mk(2'b11, 1, 1, 2'b01, 1, 0, 1);
        tbl[10] = mk(2'b00, 0, 1, 2'b00, 0, 0, 1);
        // fill the table, then pop while full: no grant until the next cycle
        tbl[11] = mk(2'b11, 1, 0, 2'b10, 1, 1, 0);
        tbl[12] = mk(2'b11, 1, 0, 2'b01, 1, 0, 1);
        tbl[13] = mk(2'b11, 1, 0, 2'b00, 0, 0, 1);
        tbl[14] = mk(2'b11, 1, 1, 2'b00, 0, 0, 1);
        tbl[15] = mk(2'b11, 1, 0, 2'b10, 1, 1, 1);
        tbl[16] = mk(2'b00, 0, 1, 2'b00, 0, 0, 1);
        tbl[17] = mk(2'b00, 0, 1, 2'b00, 0, 0, 1);
        // spurious response
        tbl[18] = mk(2'b00, 0, 1, 2'b00, 0, 0, 0);
        tbl[19] = mk(2'b00, 0, 0, 2'b00, 0, 0, 0);
        // locked plug drops its request: re-arbitrate in the same cycle
        tbl[20] = mk(2'b10, 0, 0, 2'b00, 1, 1, 0);
        tbl[21] = mk(2'b01, 1, 0, 2'b01, 1, 0, 0);
        tbl[22] = mk(2'b00, 0, 1, 2'b00, 0, 0, 1);

        #2;
        check_reset_outputs();
        #10 rst_n = 1'b1;

        for (int i = 0; i < 23; i++) run_row(tbl[i]);

        // reset with two grants outstanding and prio_q left at 1
        run_row(mk(2'b10, 1, 0, 2'b10, 1, 1, 0));
        run_row(mk(2'b01, 1, 0, 2'b01, 1, 0, 1));
        @(posedge clk); #1;
        plug_req    = '0;
        per_gnt     = 1'b0;
        per_r_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        exp_q.delete();
        @(negedge clk); #2 rst_n = 1'b1;
        run_row(mk(2'b00, 0, 1, 2'b00, 0, 0, 0));
        run_row(mk(2'b11, 1, 0, 2'b01, 1, 0, 0));
        run_row(mk(2'b00, 0, 1, 2'b00, 0, 0, 1));
        run_row(mk(2'b00, 0, 0, 2'b00, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
